cluster_task_dispatcher: RTL and testbench



---
 rtl/cluster_task_dispatcher.sv | 154 +++++++++++++++
 tb/tb_cluster_task_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_task_dispatcher.sv
// cluster_task_dispatcher
//
// Takes one task descriptor at a time from an upstream valid/ready port and
// forwards it to one of NUM_CLUSTERS compute clusters. Clusters are tried in
// round-robin order, starting from the cluster after the last one served.
// A cluster is skipped while its outstanding-task count is at CLUSTER_CAP.
// Completion pulses from the clusters decrement their counts.
//
// Ports
//   clk_i                 clock, all state on the rising edge
//   rst_ni                asynchronous active-low reset
//   en_i                  dispatch enable; low freezes target selection
//   task_valid_i/ready_o  inbound task handshake
//   task_i                inbound task descriptor (TASK_W bits)
//   cluster_task_valid_o  one-hot valid towards the chosen cluster
//   cluster_task_ready_i  per-cluster ready
//   cluster_task_o        shared descriptor bus, always shows the held task
//   cluster_feedback_i    per-cluster completion pulse, one per finished task
//   cluster_occup_o       packed outstanding counts, cluster i at [i*OCC_W +: OCC_W]
//   underflow_o           sticky: a completion arrived for an idle cluster
module cluster_task_dispatcher #(
  parameter int NUM_CLUSTERS = 4,
  parameter int CLUSTER_CAP  = 20,
  parameter int TASK_W       = 512,
  localparam int OCC_W       = $clog2(CLUSTER_CAP) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          task_valid_i,
  output logic                          task_ready_o,
  input  logic [TASK_W-1:0]             task_i,
  output logic [NUM_CLUSTERS-1:0]       cluster_task_valid_o,
  input  logic [NUM_CLUSTERS-1:0]       cluster_task_ready_i,
  output logic [TASK_W-1:0]             cluster_task_o,
  input  logic [NUM_CLUSTERS-1:0]       cluster_feedback_i,
  output logic [NUM_CLUSTERS*OCC_W-1:0] cluster_occup_o,
  output logic                          underflow_o
);

  localparam int PTR_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        target;
  logic [PTR_W-1:0]        pick;
  logic                    pick_found;
  logic [TASK_W-1:0]       held_task;
  logic [OCC_W-1:0]        occ [NUM_CLUSTERS];
  logic [NUM_CLUSTERS-1:0] inc;
  logic [NUM_CLUSTERS-1:0] at_zero;
  logic                    handshake;

  // (base + offset) mod NUM_CLUSTERS for offsets below NUM_CLUSTERS
  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int offset);
    int sum;
    sum = base + offset;
    if (sum >= NUM_CLUSTERS) sum = sum - NUM_CLUSTERS;
    return PTR_W'(sum);
  endfunction

  assign task_ready_o   = (state == IDLE);
  assign cluster_task_o = held_task;
  assign handshake      = (state == SEND) && |(cluster_task_valid_o & cluster_task_ready_i);
  assign inc            = handshake ? cluster_task_valid_o : '0;

  // Round-robin search over the registered counts. Walking the offsets from
  // the far end lets the nearest free cluster to rr_ptr overwrite the others.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = NUM_CLUSTERS - 1; k >= 0; k--) begin
      if (occ[wrap_idx(int'(rr_ptr), k)] < OCC_W'(CLUSTER_CAP)) begin
        pick       = wrap_idx(int'(rr_ptr), k);
        pick_found = 1'b1;
      end
    end
  end

  // Clusters whose count is already zero; a completion here is an underflow
  always_comb begin
    at_zero = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      at_zero[i] = (occ[i] == '0);
    end
  end

  // Dispatch FSM. The one-hot valid is registered when the target is chosen
  // and only cleared by the handshake, so it can never move while waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      target               <= '0;
      held_task            <= '0;
      cluster_task_valid_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (task_valid_i) begin
            held_task <= task_i;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (en_i && pick_found) begin
            target               <= pick;
            cluster_task_valid_o <= NUM_CLUSTERS'(1) << pick;
            state                <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            cluster_task_valid_o <= '0;
            rr_ptr               <= (int'(target) == NUM_CLUSTERS - 1) ? '0 : target + 1'b1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding-task counters. A dispatch and a completion on the same
  // cluster in the same cycle cancel out. Counts cannot pass CLUSTER_CAP
  // because a cluster is only chosen below the cap and only one task is in
  // flight at a time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        occ[i] <= '0;
      end
      underflow_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        if (inc[i] && !cluster_feedback_i[i]) begin
          occ[i] <= occ[i] + 1'b1;
        end else if (!inc[i] && cluster_feedback_i[i] && !at_zero[i]) begin
          occ[i] <= occ[i] - 1'b1;
        end
      end
      if (|(cluster_feedback_i & at_zero)) begin
        underflow_o <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_occ_out
    assign cluster_occup_o[g*OCC_W +: OCC_W] = occ[g];
  end

endmodule

// File: tb/tb_cluster_task_dispatcher.sv
// Testbench for cluster_task_dispatcher: fixed vector table, directed
// corner-case sequences and a randomized phase, all checked against a
// transaction-level model of the per-cluster counts and round-robin pointer.
module tb_cluster_task_dispatcher;

  localparam int N   = 4;
  localparam int CAP = 20;
  localparam int TW  = 512;
  localparam int OW  = $clog2(CAP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          task_valid = 1'b0;
  logic          task_ready;
  logic [TW-1:0] task_data = '0;
  logic [N-1:0]  valid_out;
  logic [N-1:0]  ready_in = '0;
  logic [TW-1:0] task_out;
  logic [N-1:0]  feedback = '0;
  logic [N*OW-1:0] occup;
  logic          underflow;

  // reference model state
  int mocc [N];
  int mrr;
  bit munder;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [TW-1:0] data;
    int            exp_target;
    int            exp_occ;
  } vec_t;

  vec_t vec [6];

  cluster_task_dispatcher #(
    .NUM_CLUSTERS(N),
    .CLUSTER_CAP (CAP),
    .TASK_W      (TW)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .en_i                (en),
    .task_valid_i        (task_valid),
    .task_ready_o        (task_ready),
    .task_i              (task_data),
    .cluster_task_valid_o(valid_out),
    .cluster_task_ready_i(ready_in),
    .cluster_task_o      (task_out),
    .cluster_feedback_i  (feedback),
    .cluster_occup_o     (occup),
    .underflow_o         (underflow)
  );

  always #5 clk = ~clk;

  // absolute time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [TW-1:0] actual, input logic [TW-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int occOf(input int i);
    return int'(occup[i*OW +: OW]);
  endfunction

  function automatic logic [TW-1:0] randData();
    logic [TW-1:0] d;
    for (int i = 0; i < TW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // first cluster below the cap, counting up from the pointer, or -1
  function automatic int modelPick();
    for (int k = 0; k < N; k++) begin
      if (mocc[(mrr + k) % N] < CAP) return (mrr + k) % N;
    end
    return -1;
  endfunction

  task automatic modelFeedback(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (mocc[i] > 0) mocc[i]--;
        else munder = 1'b1;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    for (int i = 0; i < N; i++) checkOutput($sformatf("%s_occ%0d", tag, i), occOf(i), mocc[i]);
    checkOutput({tag, "_underflow"}, underflow, munder);
  endtask

  task automatic pulseFeedback(input logic [N-1:0] mask);
    feedback = mask;
    tick();
    feedback = '0;
    modelFeedback(mask);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    en = 1'b1;
    task_valid = 1'b0;
    ready_in = '0;
    feedback = '0;
    task_data = '0;
    for (int i = 0; i < N; i++) mocc[i] = 0;
    mrr = 0;
    munder = 1'b0;
    #3;
    checkModel("in_reset");
    checkOutput("reset_valid", valid_out, '0);
    checkOutput("reset_task", task_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", task_ready, 1);
  endtask

  // One complete dispatch: accept, optional frozen SELECT cycles, optional
  // stall on the cluster ready, handshake with optional coincident feedback.
  task automatic applyStimulus(input logic [TW-1:0] data, input int en_off, input int hold,
                               input logic [N-1:0] hs_fb, output int got);
    int exp_t;
    int waited;
    logic [N-1:0] exp_v;
    got = -1;
    exp_t = modelPick();
    exp_v = N'(1) << exp_t;
    checkOutput("ready_idle", task_ready, 1);
    en = (en_off == 0);
    task_valid = 1'b1;
    task_data = data;
    tick();
    task_valid = 1'b0;
    task_data = ~data;
    checkOutput("ready_busy", task_ready, 0);
    for (int k = 0; k < en_off; k++) begin
      checkOutput("valid_frozen", valid_out, '0);
      tick();
    end
    en = 1'b1;
    waited = 0;
    while (valid_out == '0 && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("select_latency", waited, 1);
    checkOutput("valid_onehot", valid_out, exp_v);
    if (valid_out == '0) return;
    for (int i = 0; i < N; i++) if (valid_out[i]) got = i;
    for (int k = 0; k < hold; k++) begin
      ready_in = N'($urandom) & ~exp_v;
      checkOutput("valid_hold", valid_out, exp_v);
      checkOutput("task_hold", task_out, data);
      checkOutput("ready_hold", task_ready, 0);
      tick();
    end
    checkOutput("task_at_handshake", task_out, data);
    ready_in = '1;
    feedback = hs_fb;
    tick();
    ready_in = '0;
    feedback = '0;
    for (int i = 0; i < N; i++) begin
      if (i == exp_t) begin
        if (!hs_fb[i]) mocc[i]++;
      end else if (hs_fb[i]) begin
        if (mocc[i] > 0) mocc[i]--;
        else munder = 1'b1;
      end
    end
    mrr = (exp_t + 1) % N;
    checkOutput("valid_after_hs", valid_out, '0);
    checkOutput("ready_after_hs", task_ready, 1);
    checkModel("post_send");
  endtask

  initial begin
    int got;
    logic [TW-1:0] d;
    logic [N-1:0] occm;

    vec[0] = '{data: {16{32'hC0DE_0000}}, exp_target: 0, exp_occ: 1};
    vec[1] = '{data: {16{32'hC0DE_0001}}, exp_target: 1, exp_occ: 1};
    vec[2] = '{data: {16{32'hC0DE_0002}}, exp_target: 2, exp_occ: 1};
    vec[3] = '{data: {16{32'hC0DE_0003}}, exp_target: 3, exp_occ: 1};
    vec[4] = '{data: {16{32'hC0DE_0004}}, exp_target: 0, exp_occ: 2};
    vec[5] = '{data: {16{32'hC0DE_0005}}, exp_target: 1, exp_occ: 2};

    $display("[TB] start");
    applyReset();

    // back-to-back tasks from reset rotate through the clusters
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec[i].data, 0, 0, '0, got);
      checkOutput($sformatf("vec%0d_target", i), got, vec[i].exp_target);
      checkOutput($sformatf("vec%0d_occ", i), occOf(vec[i].exp_target), vec[i].exp_occ);
      if (i == 3) checkModel("after_four");
    end

    // fill cluster 0 to the cap, returning the others to zero, pointer to 0
    applyReset();
    while (mocc[0] < CAP || mrr != 0) begin
      applyStimulus(randData(), 0, 0, '0, got);
      if (got > 0) pulseFeedback(N'(1) << got);
    end
    d = randData();
    applyStimulus(d, 0, 0, '0, got);
    checkOutput("skip_full_target", got, 1);
    checkOutput("skip_full_occ1", occOf(1), 1);
    applyStimulus(randData(), 0, 0, '0, got);
    checkOutput("skip_full_next", got, 2);

    // fill everything, then a task must wait in SELECT
    while (modelPick() >= 0) applyStimulus(randData(), 0, 0, '0, got);
    checkModel("all_full");
    d = randData();
    checkOutput("full_ready_idle", task_ready, 1);
    task_valid = 1'b1;
    task_data = d;
    tick();
    task_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("full_no_valid", valid_out, '0);
      checkOutput("full_ready_low", task_ready, 0);
      tick();
    end
    pulseFeedback(4'b0100);
    checkOutput("fb_same_cycle_no_valid", valid_out, '0);
    checkOutput("fb_occ2", occOf(2), 19);
    tick();
    checkOutput("full_pick2", valid_out, 4'b0100);
    checkOutput("full_task", task_out, d);
    ready_in = '1;
    tick();
    ready_in = '0;
    mocc[2]++;
    mrr = 3;
    checkOutput("full_occ2_back", occOf(2), 20);
    checkModel("after_full");

    // coincident dispatch and completion, then an underflow
    while (mocc[0] > 0 || mocc[3] > 5) begin
      pulseFeedback({(mocc[3] > 5), 2'b00, (mocc[0] > 0)});
    end
    applyStimulus(randData(), 0, 0, 4'b1000, got);
    checkOutput("coincident_target", got, 3);
    checkOutput("coincident_occ3", occOf(3), 5);
    checkOutput("underflow_before", underflow, 0);
    pulseFeedback(4'b0001);
    checkOutput("underflow_set", underflow, 1);
    checkOutput("underflow_occ0", occOf(0), 0);
    tick();
    tick();
    checkOutput("underflow_sticky", underflow, 1);

    // stalled SEND to cluster 1
    pulseFeedback(4'b0010);
    applyStimulus(randData(), 0, 0, '0, got);
    checkOutput("pre_stall_target", got, 0);
    applyStimulus(randData(), 0, 5, '0, got);
    checkOutput("stall_target", got, 1);

    // selection frozen by the enable for ten cycles
    applyStimulus(randData(), 10, 0, '0, got);
    checkOutput("enable_target", got, 3);

    // reset while a task is on offer drops it
    d = randData();
    task_valid = 1'b1;
    task_data = d;
    tick();
    task_valid = 1'b0;
    tick();
    checkOutput("valid_before_reset", valid_out, N'(1) << modelPick());
    #2;
    applyReset();
    checkOutput("after_drop_valid", valid_out, '0);
    checkModel("after_drop");

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) occm[i] = (mocc[i] > 0);
      if ($urandom_range(0, 3) == 0 && occm != '0) begin
        pulseFeedback(N'($urandom) & occm);
        checkModel("rand_fb");
      end else begin
        applyStimulus(randData(), $urandom_range(0, 2), $urandom_range(0, 3), N'($urandom) & occm, got);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
